// File: rtl/data_sram_resp_pkg.sv
// Shared constants for the data_sram responder: confreg window base, register
// offsets and default RAM geometry.
package data_sram_resp_pkg;

    localparam int unsigned DATA_RAM_AW       = 12;
    localparam logic [15:0] CONF_BASE_DEFAULT = 16'hbfaf;

    localparam logic [15:0] CONF_LED   = 16'hf000;
    localparam logic [15:0] CONF_NUM   = 16'hf010;
    localparam logic [15:0] CONF_SW    = 16'hf020;
    localparam logic [15:0] CONF_TIMER = 16'he000;

    // Confreg registers only accept full-word stores.
    function automatic logic is_full_word(input logic [3:0] wen);
        return wen == 4'hf;
    endfunction

endpackage

// File: rtl/data_sram_bank.sv
// Byte-enabled single-port word RAM with registered read; rdata holds unless
// a read is performed.
module data_sram_bank
    import data_sram_resp_pkg::*;
#(
    parameter int unsigned AW = DATA_RAM_AW
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    wen,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1 << AW) - 1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (wen == 4'h0) begin
                rdata <= mem[idx];
            end else begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (wen[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// Data-side memory responder: word RAM in the low space plus the confreg window
// (LED, seven-segment number, switches, timer), one-cycle read latency.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int unsigned RAM_AW    = DATA_RAM_AW,
    parameter logic [15:0] CONF_BASE = CONF_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led,
    output logic [31:0] num_data
);

    logic        conf_sel;
    logic [15:0] conf_off;
    logic        is_read;
    logic        conf_wr;
    logic        ram_en;
    logic [31:0] conf_rd_val;
    logic [31:0] timer;
    logic [31:0] bank_rdata;
    logic        conf_sel_q;
    logic [31:0] conf_rdata_q;

    assign conf_sel = (data_sram_addr[31:16] == CONF_BASE);
    assign conf_off = data_sram_addr[15:0];
    assign is_read  = data_sram_en && (data_sram_wen == 4'h0);
    assign conf_wr  = data_sram_en && conf_sel && is_full_word(data_sram_wen);
    assign ram_en   = data_sram_en && !conf_sel && !rst;

    data_sram_bank #(
        .AW (RAM_AW)
    ) u_bank (
        .clk   (clk),
        .en    (ram_en),
        .wen   (data_sram_wen),
        .idx   (data_sram_addr[RAM_AW+1:2]),
        .wdata (data_sram_wdata),
        .rdata (bank_rdata)
    );

    always_comb begin
        conf_rd_val = '0;
        case (conf_off)
            CONF_LED:   conf_rd_val = {16'h0, led};
            CONF_NUM:   conf_rd_val = num_data;
            CONF_SW:    conf_rd_val = {24'h0, switch_in};
            CONF_TIMER: conf_rd_val = timer;
            default:    conf_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led      <= '0;
            num_data <= '0;
            timer    <= '0;
        end else begin
            timer <= timer + 32'd1;
            if (conf_wr) begin
                case (conf_off)
                    CONF_LED:   led      <= data_sram_wdata[15:0];
                    CONF_NUM:   num_data <= data_sram_wdata;
                    CONF_TIMER: timer    <= data_sram_wdata;
                    default:    ;
                endcase
            end
        end
    end

    // Reset parks the output mux on the cleared confreg path so rdata reads 0
    // without having to reset the RAM's own read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            conf_sel_q   <= 1'b1;
            conf_rdata_q <= '0;
        end else if (is_read) begin
            conf_sel_q <= conf_sel;
            if (conf_sel) begin
                conf_rdata_q <= conf_rd_val;
            end
        end
    end

    assign data_sram_rdata = conf_sel_q ? conf_rdata_q : bank_rdata;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: behavioural memory/confreg model checked
// every cycle, plus literal expectations at key points of the sequence.
module tb_data_sram_resp;

    logic        clk;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch_in;
    logic [15:0] led;
    logic [31:0] num_data;

    int checks = 0;
    int errors = 0;

    data_sram_resp #(
        .RAM_AW    (12),
        .CONF_BASE (16'hbfaf)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch_in       (switch_in),
        .led             (led),
        .num_data        (num_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Behavioural model: byte-granular memory, confreg values, timer.
    logic [7:0]  m_mem [int];
    logic [31:0] m_rdata;
    logic        m_known;
    logic [15:0] m_led;
    logic [31:0] m_num;
    logic [31:0] m_timer;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        logic [31:0] pre;
        int          base;
        if (rst) begin
            m_rdata = 32'h0;
            m_known = 1'b1;
            m_led   = 16'h0;
            m_num   = 32'h0;
            m_timer = 32'h0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            pre     = m_timer;
            m_timer = m_timer + 32'd1;
            if (data_sram_en) begin
                if (data_sram_addr[31:16] == 16'hbfaf) begin
                    if (data_sram_wen == 4'h0) begin
                        m_known = 1'b1;
                        if (data_sram_addr[15:0] == 16'hf000)      m_rdata = {16'h0, m_led};
                        else if (data_sram_addr[15:0] == 16'hf010) m_rdata = m_num;
                        else if (data_sram_addr[15:0] == 16'hf020) m_rdata = {24'h0, switch_in};
                        else if (data_sram_addr[15:0] == 16'he000) m_rdata = pre;
                        else                                       m_rdata = 32'h0;
                    end else if (data_sram_wen == 4'hf) begin
                        if (data_sram_addr[15:0] == 16'hf000)      m_led   = data_sram_wdata[15:0];
                        else if (data_sram_addr[15:0] == 16'hf010) m_num   = data_sram_wdata;
                        else if (data_sram_addr[15:0] == 16'he000) m_timer = data_sram_wdata;
                    end
                end else begin
                    base = int'((data_sram_addr >> 2) % 4096) * 4;
                    if (data_sram_wen == 4'h0) begin
                        m_known = 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (m_mem.exists(base + b)) m_rdata[8*b +: 8] = m_mem[base + b];
                            else m_known = 1'b0;
                        end
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (data_sram_wen[b]) m_mem[base + b] = data_sram_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            if (m_known) chk("model_rdata", data_sram_rdata, m_rdata);
            chk("model_led", {16'h0, led}, {16'h0, m_led});
            chk("model_num", num_data, m_num);
        end
    end

    task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        data_sram_en    = e;
        data_sram_wen   = w;
        data_sram_addr  = a;
        data_sram_wdata = d;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        switch_in = 8'h00;
        idle(2);
        chk("reset_rdata", data_sram_rdata, 32'h0);
        chk("reset_led", {16'h0, led}, 32'h0);
        chk("reset_num", num_data, 32'h0);
        rst = 1'b0;

        idle(5);
        cyc(1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
        chk("timer_cycle5", data_sram_rdata, 32'd5);

        cyc(1'b1, 4'hf, 32'h0000_0010, 32'hdead_beef);
        cyc(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        chk("ram_read", data_sram_rdata, 32'hdead_beef);
        idle(2);
        chk("ram_hold_idle", data_sram_rdata, 32'hdead_beef);

        cyc(1'b1, 4'hf, 32'h0000_0100, 32'h1122_3344);
        cyc(1'b1, 4'b0010, 32'h0000_0100, 32'h0000_aa00);
        cyc(1'b1, 4'h0, 32'h0000_0100, 32'h0);
        chk("ram_byte_merge", data_sram_rdata, 32'h1122_aa44);
        cyc(1'b1, 4'h0, 32'h0000_4100, 32'h0);
        chk("ram_alias", data_sram_rdata, 32'h1122_aa44);
        cyc(1'b1, 4'hf, 32'h0000_0200, 32'hcafe_f00d);
        chk("ram_hold_write", data_sram_rdata, 32'h1122_aa44);
        cyc(1'b1, 4'h0, 32'h0000_0200, 32'h0);
        chk("ram_read_after_write", data_sram_rdata, 32'hcafe_f00d);

        cyc(1'b1, 4'hf, 32'hbfaf_f000, 32'h0000_5a5a);
        chk("led_write", {16'h0, led}, 32'h0000_5a5a);
        cyc(1'b1, 4'h0, 32'hbfaf_f000, 32'h0);
        chk("led_read", data_sram_rdata, 32'h0000_5a5a);
        cyc(1'b1, 4'h1, 32'hbfaf_f000, 32'hffff_ffff);
        chk("led_partial_ignored", {16'h0, led}, 32'h0000_5a5a);

        cyc(1'b1, 4'hf, 32'hbfaf_f010, 32'h1234_5678);
        chk("num_write", num_data, 32'h1234_5678);
        cyc(1'b1, 4'h0, 32'hbfaf_f010, 32'h0);
        chk("num_read", data_sram_rdata, 32'h1234_5678);

        switch_in = 8'hc3;
        cyc(1'b1, 4'h0, 32'hbfaf_f020, 32'h0);
        chk("switch_read", data_sram_rdata, 32'h0000_00c3);
        cyc(1'b1, 4'hf, 32'hbfaf_f020, 32'hffff_ffff);
        switch_in = 8'h3c;
        cyc(1'b1, 4'h0, 32'hbfaf_f020, 32'h0);
        chk("switch_ro", data_sram_rdata, 32'h0000_003c);
        cyc(1'b1, 4'h0, 32'hbfaf_f0f0, 32'h0);
        chk("conf_unmapped", data_sram_rdata, 32'h0);

        cyc(1'b1, 4'hf, 32'hbfaf_e000, 32'hffff_fffe);
        idle(1);
        cyc(1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
        chk("timer_after_write", data_sram_rdata, 32'hffff_ffff);
        cyc(1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
        chk("timer_wrap", data_sram_rdata, 32'h0);

        cyc(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        chk("pre_reset_read", data_sram_rdata, 32'hdead_beef);
        rst = 1'b1;
        cyc(1'b1, 4'hf, 32'h0000_0100, 32'h0);
        chk("midrst_rdata", data_sram_rdata, 32'h0);
        chk("midrst_led", {16'h0, led}, 32'h0);
        chk("midrst_num", num_data, 32'h0);
        rst = 1'b0;
        cyc(1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
        chk("midrst_timer", data_sram_rdata, 32'h0);
        cyc(1'b1, 4'h0, 32'h0000_0100, 32'h0);
        chk("ram_survives_reset", data_sram_rdata, 32'h1122_aa44);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
